// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one physical memory port between instruction fetch (read-only)
//   and load/store (read/write). One transaction is outstanding at a time:
//   a request is accepted in IDLE, presented to memory in ISSUE until the
//   memory accepts it, and its response is routed back to the owner in WAIT.
//
//   Arbitration (default build): LSU has priority, but after STARVE_LIMIT
//   consecutive LSU grants with a fetch waiting, the fetch wins one grant.
//   Optional macro MEM_ARB_RR_EN: round-robin on simultaneous requests
//   instead (last-grant flag resets to IF, so LSU wins the first tie).
//
// Ports
//   clock, reset            rising-edge clock; asynchronous active-low reset
//   if_req_*                fetch request (valid/ready/addr)
//   if_resp_*               fetch response (1-cycle valid pulse, held data)
//   ls_req_*                load/store request (valid/ready/wr/addr/wdata/size)
//   ls_resp_*               load/store response (1-cycle valid pulse, held data)
//   mem_req_*               request toward memory (valid/ready/wr/addr/wdata/size)
//   mem_resp_*              memory response (valid/data)
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  if_req_valid,
    output logic                  if_req_ready,
    input  logic [ADDR_WIDTH-1:0] if_req_addr,
    output logic                  if_resp_valid,
    output logic [DATA_WIDTH-1:0] if_resp_data,
    input  logic                  ls_req_valid,
    output logic                  ls_req_ready,
    input  logic                  ls_req_wr,
    input  logic [ADDR_WIDTH-1:0] ls_req_addr,
    input  logic [DATA_WIDTH-1:0] ls_req_wdata,
    input  logic [3:0]            ls_req_size,
    output logic                  ls_resp_valid,
    output logic [DATA_WIDTH-1:0] ls_resp_data,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_wr,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    output logic [3:0]            mem_req_size,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

    state_t state;
    logic   owner_ls;      // 1 = LSU owns the in-flight transaction
    logic   grant_if;
    logic   grant_ls;
    logic   tie_to_if;     // on a simultaneous request, the fetch wins

`ifdef MEM_ARB_RR_EN
    logic   last_ls;       // last grant went to LSU
`else
    logic [3:0] starve_cnt;
`endif

    always_comb begin
`ifdef MEM_ARB_RR_EN
        tie_to_if = last_ls;
`else
        tie_to_if = (starve_cnt == 4'(STARVE_LIMIT));
`endif
        grant_ls = 1'b0;
        grant_if = 1'b0;
        // Gated by reset so both readies are low while reset is asserted.
        if (reset && state == ST_IDLE) begin
            if (ls_req_valid && !(if_req_valid && tie_to_if))
                grant_ls = 1'b1;
            else if (if_req_valid)
                grant_if = 1'b1;
        end
    end

    assign if_req_ready = grant_if;
    assign ls_req_ready = grant_ls;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            owner_ls      <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_wr    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_size  <= '0;
            if_resp_valid <= 1'b0;
            if_resp_data  <= '0;
            ls_resp_valid <= 1'b0;
            ls_resp_data  <= '0;
`ifdef MEM_ARB_RR_EN
            last_ls       <= 1'b0;
`else
            starve_cnt    <= '0;
`endif
        end else begin
            if_resp_valid <= 1'b0;
            ls_resp_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (grant_ls) begin
                        owner_ls      <= 1'b1;
                        mem_req_wr    <= ls_req_wr;
                        mem_req_addr  <= ls_req_addr;
                        mem_req_wdata <= ls_req_wdata;
                        mem_req_size  <= ls_req_size;
                        mem_req_valid <= 1'b1;
                        state         <= ST_ISSUE;
                    end else if (grant_if) begin
                        owner_ls      <= 1'b0;
                        mem_req_wr    <= 1'b0;
                        mem_req_addr  <= if_req_addr;
                        mem_req_wdata <= '0;
                        mem_req_size  <= 4'b1000;
                        mem_req_valid <= 1'b1;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        if (owner_ls) begin
                            ls_resp_valid <= 1'b1;
                            ls_resp_data  <= mem_resp_data;
                        end else begin
                            if_resp_valid <= 1'b1;
                            if_resp_data  <= mem_resp_data;
                        end
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

`ifdef MEM_ARB_RR_EN
            if (grant_ls)
                last_ls <= 1'b1;
            else if (grant_if)
                last_ls <= 1'b0;
`else
            // Counts LSU wins over a waiting fetch; saturates at the limit.
            if (grant_if)
                starve_cnt <= '0;
            else if (grant_ls && if_req_valid && starve_cnt != 4'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + 4'd1;
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned LIMIT = 4;

    logic          clock;
    logic          reset;
    logic          if_req_valid, if_req_ready, if_resp_valid;
    logic [AW-1:0] if_req_addr;
    logic [DW-1:0] if_resp_data;
    logic          ls_req_valid, ls_req_ready, ls_req_wr, ls_resp_valid;
    logic [AW-1:0] ls_req_addr;
    logic [DW-1:0] ls_req_wdata, ls_resp_data;
    logic [3:0]    ls_req_size;
    logic          mem_req_valid, mem_req_ready, mem_req_wr, mem_resp_valid;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_wdata, mem_resp_data;
    logic [3:0]    mem_req_size;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_wr(ls_req_wr),
        .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata), .ls_req_size(ls_req_size),
        .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wr(mem_req_wr),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_size(mem_req_size),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned passed = 0;
    int unsigned failed = 0;
    int unsigned total  = 0;

    // Transaction-level reference: one pending transaction plus arbitration history.
    bit            m_busy, m_issued, m_own_ls, m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [3:0]    m_size;
    int            m_starve;
    bit            m_last_ls;
    bit            m_if_pulse, m_ls_pulse;
    logic [DW-1:0] m_if_data, m_ls_data;
    bit            hs_if, hs_ls;
    bit            grants[$];          // 1 = LSU granted, 0 = IF granted
    logic [DW-1:0] mem [16];
    int            rdy_pct = 100;
    int            spur_pct = 0;
    int            resp_delay = 0;     // negative = random 0..3
    int            resp_cd = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_issued = 0; m_own_ls = 0; m_wr = 0;
        m_addr = '0; m_wdata = '0; m_size = '0;
        m_starve = 0; m_last_ls = 0;
        m_if_pulse = 0; m_ls_pulse = 0;
        m_if_data = '0; m_ls_data = '0;
    endtask

    function automatic bit exp_grant_ls();
        if (!reset || m_busy || !ls_req_valid) return 1'b0;
        if (!if_req_valid) return 1'b1;
`ifdef MEM_ARB_RR_EN
        return !m_last_ls;
`else
        return m_starve < LIMIT;
`endif
    endfunction

    function automatic bit exp_grant_if();
        return reset && !m_busy && if_req_valid && !exp_grant_ls();
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_rdy"}, {if_req_ready, ls_req_ready}, 2'b00);
        check({tag, "_vld"}, {mem_req_valid, if_resp_valid, ls_resp_valid, mem_req_wr}, 4'b0);
        check({tag, "_addr"}, mem_req_addr, 0);
        check({tag, "_wdata"}, mem_req_wdata, 0);
        check({tag, "_size"}, mem_req_size, 0);
        check({tag, "_rdata"}, {if_resp_data, ls_resp_data}, 0);
    endtask

    // One clock cycle: memory-side drive, output checks, reference update.
    // Entered just after a falling edge with requester inputs already set.
    task automatic step();
        bit g_if, g_ls;
        if (m_busy && m_issued) begin
            if (resp_cd == 0) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = m_wr ? m_wdata : mem[m_addr[5:2]];
            end else begin
                resp_cd--;
                mem_resp_valid = 1'b0;
                mem_resp_data  = $urandom;
            end
        end else begin
            mem_resp_valid = ($urandom_range(99) < spur_pct);
            mem_resp_data  = $urandom;
        end
        mem_req_ready = ($urandom_range(99) < rdy_pct);
        #1;
        g_ls = exp_grant_ls();
        g_if = exp_grant_if();
        if (!reset) begin
            check_all_zero("in_reset");
        end else begin
            check("if_req_ready", if_req_ready, g_if);
            check("ls_req_ready", ls_req_ready, g_ls);
            check("mem_req_valid", mem_req_valid, m_busy && !m_issued);
            if (m_busy && !m_issued) begin
                check("mem_req_addr", mem_req_addr, m_addr);
                check("mem_req_wr", mem_req_wr, m_wr);
                check("mem_req_wdata", mem_req_wdata, m_wdata);
                check("mem_req_size", mem_req_size, m_size);
            end
            check("if_resp_valid", if_resp_valid, m_if_pulse);
            check("ls_resp_valid", ls_resp_valid, m_ls_pulse);
            check("if_resp_data", if_resp_data, m_if_data);
            check("ls_resp_data", ls_resp_data, m_ls_data);
        end
        @(posedge clock);
        hs_if = 0;
        hs_ls = 0;
        if (!reset) begin
            model_reset();
        end else begin
            m_if_pulse = 0;
            m_ls_pulse = 0;
            if (m_busy && m_issued) begin
                if (mem_resp_valid) begin
                    if (m_own_ls) begin m_ls_pulse = 1; m_ls_data = mem_resp_data; end
                    else begin m_if_pulse = 1; m_if_data = mem_resp_data; end
                    if (m_wr) mem[m_addr[5:2]] = m_wdata;
                    m_busy = 0;
                end
            end else if (m_busy) begin
                if (mem_req_ready) begin
                    m_issued = 1;
                    resp_cd = (resp_delay < 0) ? int'($urandom_range(3)) : resp_delay;
                end
            end else if (g_ls) begin
                m_busy = 1; m_issued = 0; m_own_ls = 1;
                m_wr = ls_req_wr; m_addr = ls_req_addr; m_wdata = ls_req_wdata; m_size = ls_req_size;
                if (if_req_valid && m_starve < LIMIT) m_starve++;
                m_last_ls = 1;
                grants.push_back(1'b1);
                hs_ls = 1;
            end else if (g_if) begin
                m_busy = 1; m_issued = 0; m_own_ls = 0;
                m_wr = 0; m_addr = if_req_addr; m_wdata = '0; m_size = 4'b1000;
                m_starve = 0;
                m_last_ls = 0;
                grants.push_back(1'b0);
                hs_if = 1;
            end
        end
        @(negedge clock);
    endtask

    task automatic wait_pulse(input bit ls, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (ls ? m_ls_pulse : m_if_pulse) break;
            step();
        end
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!m_busy && !m_if_pulse && !m_ls_pulse) break;
            step();
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [5:0] seq, exp_seq;

        for (int i = 0; i < 16; i++) mem[i] = '0;
        if_req_valid = 0; if_req_addr = '0;
        ls_req_valid = 0; ls_req_wr = 0; ls_req_addr = '0; ls_req_wdata = '0; ls_req_size = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
        model_reset();
        reset = 1'b0;
        #2;
        check_all_zero("reset");
        @(negedge clock);
        do_reset();

        // Single fetch.
        mem[0] = 32'h0280_0404;
        resp_delay = 2;
        if_req_valid = 1; if_req_addr = 32'h1C00_0000;
        step();
        if_req_valid = 0;
        #1;
        check("fetch_addr", mem_req_addr, 32'h1C00_0000);
        check("fetch_size", mem_req_size, 4'b1000);
        check("fetch_wr", mem_req_wr, 1'b0);
        wait_pulse(1'b0, 20);
        #1;
        check("fetch_resp_valid", if_resp_valid, 1'b1);
        check("fetch_resp_data", if_resp_data, 32'h0280_0404);
        check("fetch_ls_quiet", ls_resp_valid, 1'b0);
        step();
        check("fetch_pulse_width", if_resp_valid, 1'b0);

        // Store then load to the same address.
        ls_req_valid = 1; ls_req_wr = 1; ls_req_addr = 32'h100;
        ls_req_wdata = 32'hDEAD_BEEF; ls_req_size = 4'b1000;
        step();
        ls_req_valid = 0;
        #1;
        check("store_wr", mem_req_wr, 1'b1);
        wait_pulse(1'b1, 20);
        #1;
        check("store_resp_valid", ls_resp_valid, 1'b1);
        ls_req_valid = 1; ls_req_wr = 0; ls_req_wdata = '0;
        step();
        ls_req_valid = 0;
        #1;
        check("load_wr", mem_req_wr, 1'b0);
        wait_pulse(1'b1, 20);
        #1;
        check("load_resp_valid", ls_resp_valid, 1'b1);
        check("load_resp_data", ls_resp_data, 32'hDEAD_BEEF);
        wait_idle(10);

        // Backpressure: memory refuses for 5 cycles with both requesters waiting.
        rdy_pct = 0;
        if_req_valid = 1; if_req_addr = 32'h40;
        step();
        ls_req_valid = 1; ls_req_wr = 1; ls_req_addr = 32'h44; ls_req_wdata = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_addr", mem_req_addr, 32'h40);
            check("bp_ready", {if_req_ready, ls_req_ready}, 2'b00);
            check("bp_noresp", {if_resp_valid, ls_resp_valid}, 2'b00);
        end
        if_req_valid = 0; ls_req_valid = 0;
        rdy_pct = 100;
        wait_pulse(1'b0, 20);
        #1;
        check("bp_resp_valid", if_resp_valid, 1'b1);
        wait_idle(10);

        // Arbitration order under continuous contention.
        do_reset();
        resp_delay = 0;
        grants.delete();
        if_req_valid = 1; if_req_addr = 32'h20;
        ls_req_valid = 1; ls_req_wr = 0; ls_req_addr = 32'h24; ls_req_size = 4'b0100;
        for (int i = 0; i < 100; i++) begin
            if (grants.size() >= 6) break;
            step();
        end
        if_req_valid = 0; ls_req_valid = 0;
        seq = '0;
        for (int i = 0; i < 6 && i < grants.size(); i++) seq[i] = grants[i];
`ifdef MEM_ARB_RR_EN
        exp_seq = 6'b010101;   // L,I,L,I,L,I (bit 0 first)
`else
        exp_seq = 6'b101111;   // L,L,L,L,I,L (bit 0 first)
`endif
        check("grant_order", {58'd0, seq}, {58'd0, exp_seq});
        wait_idle(20);

        // Spurious memory response while idle.
        spur_pct = 100;
        for (int i = 0; i < 3; i++) begin
            step();
            check("spur_noresp", {if_resp_valid, ls_resp_valid}, 2'b00);
        end
        spur_pct = 0;
        if_req_valid = 1; if_req_addr = 32'h80;
        #1;
        check("spur_still_idle", if_req_ready, 1'b1);
        step();
        if_req_valid = 0;
        wait_pulse(1'b0, 20);
        wait_idle(10);

        // Reset while waiting for a response.
        resp_delay = 10;
        ls_req_valid = 1; ls_req_wr = 0; ls_req_addr = 32'h8;
        step();
        ls_req_valid = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_issued) break;
            step();
        end
        step();
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("midwait_reset");
        model_reset();
        step();
        reset = 1'b1;
        spur_pct = 100;
        step();
        check("post_reset_ignored", {if_resp_valid, ls_resp_valid}, 2'b00);
        step();
        spur_pct = 0;
        resp_delay = 1;
        if_req_valid = 1; if_req_addr = 32'h1C00_0000;
        step();
        if_req_valid = 0;
        wait_pulse(1'b0, 20);
        #1;
        check("post_reset_fetch_valid", if_resp_valid, 1'b1);
        check("post_reset_fetch_data", if_resp_data, 32'hDEAD_BEEF);
        wait_idle(10);

        // Randomized traffic against the reference.
        rdy_pct = 70; spur_pct = 10; resp_delay = -1;
        for (int i = 0; i < 1500; i++) begin
            if (!if_req_valid || hs_if) begin
                if_req_valid = $urandom_range(1);
                if_req_addr  = {26'd0, 4'($urandom_range(15)), 2'b00};
            end
            if (!ls_req_valid || hs_ls) begin
                ls_req_valid = $urandom_range(1);
                ls_req_wr    = $urandom_range(1);
                ls_req_addr  = {26'd0, 4'($urandom_range(15)), 2'b00};
                ls_req_wdata = $urandom;
                ls_req_size  = 4'($urandom_range(15));
            end
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single physical memory port between instruction fetch (read-only) and load/store (read/write).
- Accepts one request at a time with a valid/ready handshake and holds it stable toward memory until accepted.
- Routes the memory response back to the requester that owns the transaction.
- Sits between InstFetch/LSU and the pmem interface. Replaces the direct per-cycle pmem calls with one sequenced, single-outstanding port.

Parameters:
- ADDR_WIDTH, 32, address width of all request paths.
- DATA_WIDTH, 32, data width of read/write data.
- STARVE_LIMIT, 4, max consecutive LSU grants while a fetch is pending; range 1..15.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low; asserted when 0.
- if_req_valid  in  1  fetch request present.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_req_addr  in  ADDR_WIDTH  fetch address.
- if_resp_valid  out  1  fetch data valid (1-cycle pulse).
- if_resp_data  out  DATA_WIDTH  fetched instruction word.
- ls_req_valid  in  1  load/store request present.
- ls_req_ready  out  1  load/store request accepted this cycle.
- ls_req_wr  in  1  1 = write, 0 = read.
- ls_req_addr  in  ADDR_WIDTH  load/store address.
- ls_req_wdata  in  DATA_WIDTH  store data.
- ls_req_size  in  4  access size code, passed through unchanged.
- ls_resp_valid  out  1  load/store completion (1-cycle pulse).
- ls_resp_data  out  DATA_WIDTH  load data; memory's returned value for writes.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_req_wr  out  1  write enable.
- mem_req_addr  out  ADDR_WIDTH  address.
- mem_req_wdata  out  DATA_WIDTH  write data.
- mem_req_size  out  4  size code.
- mem_resp_valid  in  1  memory response valid.
- mem_resp_data  in  DATA_WIDTH  memory read data.

Behaviour:
- Reset (reset==0, async): state=IDLE, starvation counter=0, owner=IF.
  - All valid/ready outputs are 0.
  - All data, address and size outputs are 0.
  - An in-flight transaction is dropped with no response; memory must be reset alongside this block.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: grant is combinational, and at most one of if_req_ready/ls_req_ready is high.
  - Only LSU valid: grant LSU.
  - Only IF valid: grant IF.
  - Both valid: grant LSU unless starve_cnt==STARVE_LIMIT, in which case grant IF.
  - On handshake: latch addr/wdata/wr/size and owner into holding registers, then go to ISSUE.
  - IF requests latch wr=0, wdata=0, size=4'b1000.
- ISSUE: mem_req_valid=1, driven from the holding registers; fields stay stable until mem_req_ready. On mem_req_valid&&mem_req_ready, go to WAIT.
- WAIT: on mem_resp_valid, register mem_resp_data into the owner's resp_data, pulse the owner's resp_valid next cycle for exactly 1 cycle, and return to IDLE.
- mem_resp_valid outside WAIT is ignored.
- Both req_ready outputs are 0 in ISSUE and WAIT: single outstanding transaction.
- Latency: the accept edge at cycle N gives mem_req_valid in cycle N+1. A response arriving in cycle M gives resp_valid in cycle M+1.
  - The next request can be accepted in cycle M+1 (the response cycle and a new accept may coincide).
- Starvation counter:
  - Increments on an LSU grant while if_req_valid==1, saturating at STARVE_LIMIT.
  - Clears on any IF grant.
  - Unchanged when LSU is granted with no pending fetch.
- resp_data holds its last value while resp_valid is 0. The non-owner's resp_valid is never asserted.
- Requester inputs are sampled only at handshake; changes afterward do not affect the in-flight transaction.

Optional Feature:
- MEM_ARB_RR_EN defined: the starvation counter is replaced by round-robin arbitration.
  - On simultaneous requests, grant the requester not granted last; the last-grant flag resets to IF, so LSU wins the first tie.
  - STARVE_LIMIT is unused.
- MEM_ARB_RR_EN undefined: fixed LSU priority with the starvation limit, as described above.

Test Plan:
- Single fetch: if_req_valid=1, addr=0x1C000000, mem_req_ready=1, resp 0x02800404 three cycles after issue -> mem_req_addr=0x1C000000, mem_req_size=4'b1000, mem_req_wr=0; if_resp_valid one-cycle pulse with data 0x02800404; ls_resp_valid stays 0.
- Store then load: ls write addr=0x100, wdata=0xDEADBEEF, size=4'b1000, then read 0x100 -> mem_req_wr=1 then 0; two ls_resp_valid pulses; second ls_resp_data=0xDEADBEEF.
- Backpressure: hold mem_req_ready=0 for 5 cycles during ISSUE -> mem_req_* stable all 5 cycles; both req_ready=0; no response generated.
- Starvation, STARVE_LIMIT=4: both valid continuously -> grant order LSU,LSU,LSU,LSU,IF,LSU...; with MEM_ARB_RR_EN -> LSU,IF,LSU,IF.
- Spurious response: mem_resp_valid=1 while in IDLE -> no resp_valid on either side; state stays IDLE.
- Reset mid-WAIT: drop reset to 0 while in WAIT, then deliver mem_resp_valid after release -> all outputs 0 immediately; response ignored; a fresh fetch completes normally.
